// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, ALU encodings, control states and
// instruction classes used by the control unit, datapath and ALU.
package cpu_pkg;

    localparam int OP_NOP  = 0;
    localparam int OP_MV   = 1;
    localparam int OP_ADD  = 2;
    localparam int OP_SUB  = 3;
    localparam int OP_MVI  = 4;
    localparam int OP_AND  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_MVNZ = 8;
    localparam int OP_LD   = 9;
    localparam int OP_ST   = 10;

    localparam logic [2:0] ALU_NOP = 3'd0;
    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;
    localparam logic [2:0] ALU_XOR = 3'd5;

    typedef enum logic [2:0] {
        S_FETCH,
        S_T1,
        S_T2,
        S_T3,
        S_MWAIT
    } state_e;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_MV,
        CL_MVI,
        CL_MVNZ,
        CL_ALU,
        CL_LD,
        CL_ST,
        CL_ILL
    } instr_cls_e;

    function automatic int ir_width(input int opc_w, input int reg_addr_w);
        return opc_w + 2 * reg_addr_w;
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: maps an opcode to its instruction class and ALU operation.
module cu_decode
    import cpu_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opc,
    output instr_cls_e       cls,
    output logic [2:0]       alu_op
);

    always_comb begin
        cls    = CL_ILL;
        alu_op = ALU_NOP;
        case (int'(opc))
            OP_NOP:  cls = CL_NOP;
            OP_MV:   cls = CL_MV;
            OP_MVI:  cls = CL_MVI;
            OP_MVNZ: cls = CL_MVNZ;
            OP_LD:   cls = CL_LD;
            OP_ST:   cls = CL_ST;
            OP_ADD:  begin cls = CL_ALU; alu_op = ALU_ADD; end
            OP_SUB:  begin cls = CL_ALU; alu_op = ALU_SUB; end
            OP_AND:  begin cls = CL_ALU; alu_op = ALU_AND; end
            OP_OR:   begin cls = CL_ALU; alu_op = ALU_OR;  end
            OP_XOR:  begin cls = CL_ALU; alu_op = ALU_XOR; end
            default: cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control unit: owns IR and step state, sequences datapath
// enables for register moves, ALU ops and load/store with memory handshake.
module control_fsm
    import cpu_pkg::*;
#(
    parameter  int REG_ADDR_W  = 3,
    parameter  int OPC_W       = 4,
    parameter  int MEM_TIMEOUT = 0,
    localparam int NUM_REGS    = 2 ** REG_ADDR_W,
    localparam int IR_W        = OPC_W + 2 * REG_ADDR_W
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  run,
    input  logic [IR_W-1:0]       din,
    input  logic                  g_zero,
    input  logic                  mem_ready,
    output logic                  ir_load,
    output logic [REG_ADDR_W-1:0] rout,
    output logic [NUM_REGS-1:0]   rin,
    output logic                  ain,
    output logic                  gin,
    output logic                  gout,
    output logic                  dinout,
    output logic [2:0]            alu_op,
    output logic                  addr_in,
    output logic                  dout_in,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  done,
    output logic                  illegal,
    output logic                  bus_err
);

    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e                  state, state_nxt;
    logic [IR_W-1:0]         ir;
    logic [CNT_W-1:0]        wait_cnt;
    logic [OPC_W-1:0]        opc;
    logic [REG_ADDR_W-1:0]   rx, ry;
    logic [NUM_REGS-1:0]     rx_hot;
    instr_cls_e              cls;
    logic [2:0]              dec_alu_op;
    logic                    timed_out;

    assign opc    = ir[IR_W-1 -: OPC_W];
    assign rx     = ir[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign ry     = ir[REG_ADDR_W-1:0];
    assign rx_hot = NUM_REGS'(1) << rx;

    cu_decode #(.OPC_W(OPC_W)) u_decode (
        .opc    (opc),
        .cls    (cls),
        .alu_op (dec_alu_op)
    );

    // Counter holds the number of MWAIT cycles already spent without mem_ready.
    assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state    <= S_FETCH;
            ir       <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            if (state == S_FETCH && run)
                ir <= din;
            wait_cnt <= (state == S_MWAIT && !mem_ready) ? wait_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        ir_load   = 1'b0;
        rout      = '0;
        rin       = '0;
        ain       = 1'b0;
        gin       = 1'b0;
        gout      = 1'b0;
        dinout    = 1'b0;
        alu_op    = ALU_NOP;
        addr_in   = 1'b0;
        dout_in   = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        bus_err   = 1'b0;
        if (resetn) begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        ir_load   = 1'b1;
                        state_nxt = S_T1;
                    end
                end
                S_T1: begin
                    case (cls)
                        CL_NOP: done = 1'b1;
                        CL_MV: begin
                            rout = ry;
                            rin  = rx_hot;
                            done = 1'b1;
                        end
                        CL_MVI: begin
                            dinout = 1'b1;
                            rin    = rx_hot;
                            done   = 1'b1;
                        end
                        CL_MVNZ: begin
                            done = 1'b1;
                            if (!g_zero) begin
                                rout = ry;
                                rin  = rx_hot;
                            end
                        end
                        CL_ALU: begin
                            rout      = rx;
                            ain       = 1'b1;
                            state_nxt = S_T2;
                        end
                        CL_LD: begin
                            rout      = ry;
                            addr_in   = 1'b1;
                            state_nxt = S_MWAIT;
                        end
                        CL_ST: begin
                            rout      = ry;
                            addr_in   = 1'b1;
                            state_nxt = S_T2;
                        end
                        default: begin
                            illegal = 1'b1;
                            done    = 1'b1;
                        end
                    endcase
                end
                S_T2: begin
                    if (cls == CL_ALU) begin
                        rout      = ry;
                        gin       = 1'b1;
                        alu_op    = dec_alu_op;
                        state_nxt = S_T3;
                    end else if (cls == CL_ST) begin
                        rout      = rx;
                        dout_in   = 1'b1;
                        state_nxt = S_MWAIT;
                    end else begin
                        state_nxt = S_FETCH;
                    end
                end
                S_T3: begin
                    gout = 1'b1;
                    rin  = rx_hot;
                    done = 1'b1;
                end
                S_MWAIT: begin
                    mem_req = 1'b1;
                    mem_we  = (cls == CL_ST);
                    // A late mem_ready still completes the access over a timeout.
                    if (mem_ready) begin
                        done = 1'b1;
                        if (cls == CL_LD) begin
                            dinout = 1'b1;
                            rin    = rx_hot;
                        end
                    end else if (timed_out) begin
                        bus_err = 1'b1;
                        done    = 1'b1;
                    end
                end
                default: state_nxt = S_FETCH;
            endcase
            if (done)
                state_nxt = S_FETCH;
        end
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: one instance without memory timeout, one
// with MEM_TIMEOUT=2, driven by the same cycle-by-cycle vector table.
module tb_control_fsm;

    typedef struct packed {
        logic       ir_load;
        logic [2:0] rout;
        logic [7:0] rin;
        logic       ain;
        logic       gin;
        logic       gout;
        logic       dinout;
        logic [2:0] alu_op;
        logic       addr_in;
        logic       dout_in;
        logic       mem_req;
        logic       mem_we;
        logic       done;
        logic       illegal;
        logic       bus_err;
    } out_t;

    typedef struct {
        string      name;
        logic       rst_n;
        logic       run;
        logic [9:0] din;
        logic       gz;
        logic       mr;
        bit         sel;
        out_t       exp;
    } vec_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       run = 1'b0;
    logic [9:0] din = '0;
    logic       g_zero = 1'b0;
    logic       mem_ready = 1'b0;

    out_t act0, act1;
    int compared = 0;
    int mismatched = 0;
    vec_t vq[$];

    always #5 clock = ~clock;

    control_fsm #(.REG_ADDR_W(3), .OPC_W(4), .MEM_TIMEOUT(0)) dut0 (
        .clock(clock), .resetn(resetn), .run(run), .din(din), .g_zero(g_zero),
        .mem_ready(mem_ready), .ir_load(act0.ir_load), .rout(act0.rout),
        .rin(act0.rin), .ain(act0.ain), .gin(act0.gin), .gout(act0.gout),
        .dinout(act0.dinout), .alu_op(act0.alu_op), .addr_in(act0.addr_in),
        .dout_in(act0.dout_in), .mem_req(act0.mem_req), .mem_we(act0.mem_we),
        .done(act0.done), .illegal(act0.illegal), .bus_err(act0.bus_err)
    );

    control_fsm #(.REG_ADDR_W(3), .OPC_W(4), .MEM_TIMEOUT(2)) dut1 (
        .clock(clock), .resetn(resetn), .run(run), .din(din), .g_zero(g_zero),
        .mem_ready(mem_ready), .ir_load(act1.ir_load), .rout(act1.rout),
        .rin(act1.rin), .ain(act1.ain), .gin(act1.gin), .gout(act1.gout),
        .dinout(act1.dinout), .alu_op(act1.alu_op), .addr_in(act1.addr_in),
        .dout_in(act1.dout_in), .mem_req(act1.mem_req), .mem_we(act1.mem_we),
        .done(act1.done), .illegal(act1.illegal), .bus_err(act1.bus_err)
    );

    // Argument order: ir_load rout rin ain gin gout dinout alu_op addr_in dout_in mem_req mem_we done illegal bus_err
    function automatic out_t mk(input logic il, input logic [2:0] ro, input logic [7:0] ri,
                                input logic a, input logic g, input logic go, input logic di,
                                input logic [2:0] al, input logic ad, input logic dt,
                                input logic rq, input logic we, input logic dn,
                                input logic ill, input logic be);
        out_t o;
        o = '{il, ro, ri, a, g, go, di, al, ad, dt, rq, we, dn, ill, be};
        return o;
    endfunction

    task automatic add(input string nm, input logic rn, input logic rr, input logic [9:0] d,
                       input logic gz, input logic mr, input bit sel, input out_t e);
        vec_t v;
        v.name = nm; v.rst_n = rn; v.run = rr; v.din = d;
        v.gz = gz; v.mr = mr; v.sel = sel; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input out_t got, input out_t want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic check_bit(input string nm, input logic got, input logic want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %b, expected %b", nm, got, want);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clock);
        resetn = v.rst_n; run = v.run; din = v.din;
        g_zero = v.gz; mem_ready = v.mr;
        #2;
        check(v.name, v.sel ? act1 : act0, v.exp);
    endtask

    initial begin
        out_t z, fe;
        z  = mk(0,0,8'h00,0,0,0,0,0,0,0,0,0,0,0,0);
        fe = mk(1,0,8'h00,0,0,0,0,0,0,0,0,0,0,0,0);

        for (int i = 0; i < 3; i++) add("rst_hold", 0, 1, 10'h08A, 0, 0, 0, z);
        add("add_fetch",   1, 1, 10'h08A, 0, 0, 0, fe);
        add("add_t1",      1, 0, 10'h000, 0, 0, 0, mk(0,1,8'h00,1,0,0,0,0,0,0,0,0,0,0,0));
        add("add_t2",      1, 0, 10'h000, 0, 0, 0, mk(0,2,8'h00,0,1,0,0,1,0,0,0,0,0,0,0));
        add("add_t3",      1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h02,0,0,1,0,0,0,0,0,0,1,0,0));
        add("mvi_fetch",   1, 1, 10'h128, 0, 0, 0, fe);
        add("mvi_t1",      1, 1, 10'h217, 0, 0, 0, mk(0,0,8'h20,0,0,0,1,0,0,0,0,0,1,0,0));
        add("mvnz_fetch",  1, 1, 10'h217, 1, 0, 0, fe);
        add("mvnz_gz1",    1, 0, 10'h000, 1, 0, 0, mk(0,0,8'h00,0,0,0,0,0,0,0,0,0,1,0,0));
        add("mvnz_fetch2", 1, 1, 10'h217, 0, 0, 0, fe);
        add("mvnz_gz0",    1, 0, 10'h000, 0, 0, 0, mk(0,7,8'h04,0,0,0,0,0,0,0,0,0,1,0,0));
        add("idle",        1, 0, 10'h08A, 0, 0, 0, z);
        add("mv_fetch",    1, 1, 10'h04B, 0, 0, 0, fe);
        add("mv_t1",       1, 0, 10'h000, 0, 0, 0, mk(0,3,8'h02,0,0,0,0,0,0,0,0,0,1,0,0));
        add("nop_fetch",   1, 1, 10'h000, 0, 0, 0, fe);
        add("nop_t1",      1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h00,0,0,0,0,0,0,0,0,0,1,0,0));
        add("ld_fetch",    1, 1, 10'h25C, 0, 0, 0, fe);
        add("ld_t1",       1, 0, 10'h000, 0, 0, 0, mk(0,4,8'h00,0,0,0,0,0,1,0,0,0,0,0,0));
        add("ld_wait1",    1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h00,0,0,0,0,0,0,0,1,0,0,0,0));
        add("ld_wait2",    1, 1, 10'h3C0, 0, 0, 0, mk(0,0,8'h00,0,0,0,0,0,0,0,1,0,0,0,0));
        add("ld_wait3",    1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h00,0,0,0,0,0,0,0,1,0,0,0,0));
        add("ld_ready",    1, 0, 10'h000, 0, 1, 0, mk(0,0,8'h08,0,0,0,1,0,0,0,1,0,1,0,0));
        add("ill_fetch",   1, 1, 10'h3C0, 0, 0, 0, fe);
        add("ill_t1",      1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h00,0,0,0,0,0,0,0,0,0,1,1,0));
        add("sub_fetch",   1, 1, 10'h0CB, 0, 0, 0, fe);
        add("sub_t1",      1, 0, 10'h000, 0, 0, 0, mk(0,1,8'h00,1,0,0,0,0,0,0,0,0,0,0,0));
        add("sub_t2_rst",  0, 0, 10'h000, 0, 0, 0, z);
        add("post_rst",    1, 0, 10'h000, 0, 0, 0, z);
        add("xor_fetch",   1, 1, 10'h1D3, 0, 0, 0, fe);
        add("xor_t1",      1, 0, 10'h000, 0, 0, 0, mk(0,2,8'h00,1,0,0,0,0,0,0,0,0,0,0,0));
        add("xor_t2",      1, 0, 10'h000, 0, 0, 0, mk(0,3,8'h00,0,1,0,0,5,0,0,0,0,0,0,0));
        add("xor_t3",      1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h04,0,0,1,0,0,0,0,0,0,1,0,0));
        add("and_fetch",   1, 1, 10'h178, 0, 0, 0, fe);
        add("and_t1",      1, 0, 10'h000, 0, 0, 0, mk(0,7,8'h00,1,0,0,0,0,0,0,0,0,0,0,0));
        add("and_t2",      1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h00,0,1,0,0,3,0,0,0,0,0,0,0));
        add("and_t3",      1, 0, 10'h000, 0, 0, 0, mk(0,0,8'h80,0,0,1,0,0,0,0,0,0,1,0,0));
        add("st_fetch",    1, 1, 10'h2B0, 0, 0, 1, fe);
        add("st_t1",       1, 0, 10'h000, 0, 0, 1, mk(0,0,8'h00,0,0,0,0,0,1,0,0,0,0,0,0));
        add("st_t2",       1, 0, 10'h000, 0, 0, 1, mk(0,6,8'h00,0,0,0,0,0,0,1,0,0,0,0,0));
        add("st_wait1",    1, 0, 10'h000, 0, 0, 1, mk(0,0,8'h00,0,0,0,0,0,0,0,1,1,0,0,0));
        add("st_wait2",    1, 0, 10'h000, 0, 0, 1, mk(0,0,8'h00,0,0,0,0,0,0,0,1,1,0,0,0));
        add("st_timeout",  1, 0, 10'h000, 0, 0, 1, mk(0,0,8'h00,0,0,0,0,0,0,0,1,1,1,0,1));
        add("st_to_idle",  1, 0, 10'h000, 0, 0, 1, z);
        add("st_no_to",    1, 0, 10'h000, 0, 1, 0, mk(0,0,8'h00,0,0,0,0,0,0,0,1,1,1,0,0));
        add("st2_fetch",   1, 1, 10'h2B0, 0, 0, 1, fe);
        add("st2_t1",      1, 0, 10'h000, 0, 0, 1, mk(0,0,8'h00,0,0,0,0,0,1,0,0,0,0,0,0));
        add("st2_t2",      1, 0, 10'h000, 0, 0, 1, mk(0,6,8'h00,0,0,0,0,0,0,1,0,0,0,0,0));
        add("st2_wait1",   1, 0, 10'h000, 0, 0, 1, mk(0,0,8'h00,0,0,0,0,0,0,0,1,1,0,0,0));
        add("st2_wait2",   1, 0, 10'h000, 0, 0, 1, mk(0,0,8'h00,0,0,0,0,0,0,0,1,1,0,0,0));
        add("st2_rdy_win", 1, 0, 10'h000, 0, 1, 1, mk(0,0,8'h00,0,0,0,0,0,0,0,1,1,1,0,0));
        add("idle2",       1, 0, 10'h000, 0, 0, 0, z);

        for (int i = 0; i < vq.size(); i++) apply(vq[i]);

        // Long load: dut0 waits 19 cycles; dut1 aborts on its third wait cycle.
        @(negedge clock);
        resetn = 1; run = 1; din = 10'h25C; mem_ready = 0;
        #2 check("ldl_fetch", act0, fe);
        @(negedge clock);
        run = 0;
        #2 check("ldl_t1", act0, mk(0,4,8'h00,0,0,0,0,0,1,0,0,0,0,0,0));
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            mem_ready = (k == 19);
            #2;
            check_bit("ldl_req", act0.mem_req, 1'b1);
            check_bit("ldl_done", act0.done, k == 19);
            check_bit("ldl_to_berr", act1.bus_err, k == 2);
            if (k == 19) check_bit("ldl_rin", act0.rin[3], 1'b1);
        end
        @(negedge clock);
        mem_ready = 0;
        #2 check("ldl_back_fetch", act0, z);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
Parametrised, self-sequencing successor of the multi-cycle CPU control unit. It owns the instruction register and the step/state register, decodes a wider opcode space and drives the datapath enables for the bus mux, register file, A/G registers and ALU. It adds logic ops, conditional move and load/store with a memory ready handshake and optional timeout. Sits between the instruction/data input, the datapath and the memory port.

Parameters:
REG_ADDR_W, 3, register-select width; NUM_REGS = 2**REG_ADDR_W.
OPC_W, 4, opcode width; IR_W = OPC_W + 2*REG_ADDR_W (default 10).
MEM_TIMEOUT, 0, maximum memory wait cycles before abort; 0 disables the timeout.

Ports:
clock  in  1  system clock, all state on rising edge.
resetn  in  1  synchronous, active-low reset.
run  in  1  start request, sampled only in FETCH.
din  in  IR_W  instruction word, captured into IR in FETCH.
g_zero  in  1  datapath flag, G == 0.
mem_ready  in  1  memory completion, one-cycle pulse or level.
ir_load  out  1  IR captured this cycle (observability).
rout  out  REG_ADDR_W  register driven onto the bus.
rin  out  NUM_REGS  one-hot register write enable.
ain / gin / gout / dinout  out  1 each  A load, G load, bus<-G, bus<-din.
alu_op  out  3  ALU operation: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5.
addr_in / dout_in  out  1 each  ADDR reg <- bus, DOUT reg <- bus.
mem_req / mem_we  out  1 each  memory access request and write qualifier.
done  out  1  last cycle of the instruction.
illegal / bus_err  out  1 each  one-cycle error pulses, coincident with done.

Behaviour:
- IR fields: opc = IR[IR_W-1 -: OPC_W], Rx = next REG_ADDR_W bits, Ry = low REG_ADDR_W bits.
- States: FETCH, T1, T2, T3, MWAIT. Outputs are combinational from state, IR and inputs. Every output defaults to 0.
- Reset: on any edge with resetn=0 → state=FETCH, IR=0, wait counter=0. While resetn=0, all outputs are forced 0. Reset mid-instruction aborts it and does not assert done.
- FETCH: if run=1 → ir_load=1, IR<=din, go to T1. If run=0 → stay in FETCH with all outputs 0. Once an instruction has started, run is ignored until done.
- NOP (0): T1 done.
- MV (1): T1 rout=Ry, rin[Rx], done.
- MVI (4): T1 dinout, rin[Rx], done.
- MVNZ (8): T1 done; rout=Ry and rin[Rx] only if g_zero=0.
- ADD/SUB/AND/OR/XOR (2,3,5,6,7):
  - T1 rout=Rx, ain.
  - T2 rout=Ry, gin, alu_op per opcode.
  - T3 gout, rin[Rx], done.
- LD (9):
  - T1 rout=Ry, addr_in.
  - MWAIT: mem_req=1. Hold until mem_ready. In the mem_ready cycle also dinout, rin[Rx], done.
- ST (10):
  - T1 rout=Ry, addr_in.
  - T2 rout=Rx, dout_in.
  - MWAIT: mem_req=1, mem_we=1 until mem_ready; done in the mem_ready cycle.
- Other opcodes: T1 illegal=1, done. No register write.
- done always returns to FETCH on the next edge; back-to-back instructions incur no bubble.
- Latency in cycles including FETCH: NOP/MV/MVI/MVNZ/illegal 2, ALU 4, LD 3+w, ST 4+w (w = wait cycles).
- Timeout: the wait counter clears on MWAIT entry and increments each MWAIT cycle without mem_ready. If MEM_TIMEOUT≠0 and the count reaches MEM_TIMEOUT → bus_err=1, done=1, no rin, return to FETCH. If mem_ready arrives in the same cycle, mem_ready wins.
- rin is exactly one-hot or zero. Rx/Ry index the full register range; there is no aliasing.

Decomposition:
- cpu_pkg: opcode localparams, ALU op encodings, state encoding, field-width helpers. Shared with datapath and ALU.
- One sub-module, cu_decode: combinational, takes opcode → instruction class (nop/mv/mvi/mvnz/alu/ld/st/illegal) plus alu_op. The FSM and output logic stay in control_fsm.

Test Plan:
- Reset hold: resetn=0 for 3 cycles with run=1 and din=0x08A → all outputs 0. After release, ir_load=1 in the first cycle.
- ADD R1,R2 (din=0x08A): T1 rout=1, ain=1 → T2 rout=2, gin=1, alu_op=1 → T3 gout=1, rin=0x02, done=1 → next cycle FETCH.
- MVI R5 (0x128) then MVNZ R2,R7 (0x217) back-to-back:
  - MVI: dinout=1, rin=0x20, done on cycle 2.
  - MVNZ with g_zero=1: rin=0, done=1.
  - Repeat MVNZ with g_zero=0: rout=7, rin=0x04.
- LD R3,[R4] (0x25C), mem_ready after 3 waits: T1 rout=4, addr_in=1 → mem_req=1 for 4 cycles → on the last of these, dinout=1, rin=0x08, done=1. Total 6 cycles.
- ST R6→[R0] (0x2B0), MEM_TIMEOUT=2, mem_ready never → T1 addr_in, rout=0 → T2 dout_in, rout=6 → mem_req=mem_we=1 → bus_err=1, done=1 on the third MWAIT cycle, rin=0.
- Illegal 0x3C0 → illegal=1, done=1 in T1. Then resetn=0 in an ALU T2 → next cycle FETCH, no done, IR=0.
